// File: rtl/mem_resp_pkg.sv
// Shared encodings and types for the data-memory responder.
// Provides transfer-size codes, MMIO register offsets, fault codes and the
// pending-store entry layout used by data_mem_responder and mem_lane_align.
package mem_resp_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned LANES   = 4;
    localparam int unsigned IDX_W   = 30;   // full word address (byte addr >> 2)
    localparam int unsigned CODE_W  = 2;
    localparam int unsigned OFF_W   = 6;    // 64-byte MMIO window

    // Transfer size, MEM_type[1:0]
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // MMIO register byte offsets
    localparam logic [OFF_W-1:0] OFF_CYCLE  = 6'h00;
    localparam logic [OFF_W-1:0] OFF_TOHOST = 6'h04;
    localparam logic [OFF_W-1:0] OFF_FSTAT  = 6'h08;
    localparam logic [OFF_W-1:0] OFF_FADDR  = 6'h0C;

    // Fault codes as reported in FSTAT[1:0]
    localparam logic [CODE_W-1:0] F_NONE     = 2'd0;
    localparam logic [CODE_W-1:0] F_MISALIGN = 2'd1;
    localparam logic [CODE_W-1:0] F_RANGE    = 2'd2;
    localparam logic [CODE_W-1:0] F_CONFLICT = 2'd3;

    // One-entry store buffer: lane-aligned data plus byte mask
    typedef struct packed {
        logic               valid;
        logic [IDX_W-1:0]   word_idx;
        logic [LANES-1:0]   mask;
        logic [WORD_W-1:0]  data;
    } pend_st_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering shared by the store and load paths.
// Ports:
//   size     - transfer size (SZ_BYTE/SZ_HALF/SZ_WORD; 2'b11 yields all zeros)
//   addr_lo  - byte offset within the word
//   st_data  - right-justified store data
//   ld_word  - full 32-bit word read from memory
//   mask     - byte-lane enables for a store
//   st_lanes - store data replicated onto its target lanes
//   ld_data  - selected load bytes, right-justified and zero-filled
module mem_lane_align
    import mem_resp_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        addr_lo,
    input  logic [WORD_W-1:0] st_data,
    input  logic [WORD_W-1:0] ld_word,
    output logic [LANES-1:0]  mask,
    output logic [WORD_W-1:0] st_lanes,
    output logic [WORD_W-1:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Byte/half selection for loads
    always_comb begin
        ld_byte = 8'h00;
        case (addr_lo)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    end

    // Replicating the data onto every lane lets the mask alone pick the target
    always_comb begin
        mask     = '0;
        st_lanes = '0;
        ld_data  = '0;
        case (size)
            SZ_BYTE: begin
                mask     = 4'b0001 << addr_lo;
                st_lanes = {4{st_data[7:0]}};
                ld_data  = {24'h0, ld_byte};
            end
            SZ_HALF: begin
                mask     = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_lanes = {2{st_data[15:0]}};
                ld_data  = {16'h0, ld_half};
            end
            SZ_WORD: begin
                mask     = 4'b1111;
                st_lanes = st_data;
                ld_data  = ld_word;
            end
            default: begin
                mask     = '0;
                st_lanes = '0;
                ld_data  = '0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the CPU data-memory port: word RAM with a one-entry store
// buffer (forwarded to loads), plus MMIO CYCLE/TOHOST/FSTAT/FADDR registers.
// Ports:
//   CLK, rst    - clock, asynchronous active-high reset
//   MEM_addr    - byte address
//   MEM_WR_out  - right-justified store data
//   MEM_type    - [1:0] transfer size, [2] unused
//   MEM_rd_en   - load request (data returned combinationally)
//   MEM_wr_en   - store request
//   MEM_data    - load data, zero when no legal load
//   fault       - sticky fault flag, cleared by reading FSTAT
//   halt        - set by any write to TOHOST, held until reset
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic [31:0] MEM_addr,
    input  logic [31:0] MEM_WR_out,
    input  logic [2:0]  MEM_type,
    input  logic        MEM_rd_en,
    input  logic        MEM_wr_en,
    output logic [31:0] MEM_data,
    output logic        fault,
    output logic        halt
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

    logic [WORD_W-1:0] ram [DEPTH_WORDS];
    pend_st_t          pend;

    logic [WORD_W-1:0] cycle_q;
    logic [WORD_W-1:0] tohost_q;
    logic [CODE_W-1:0] fstat_q;
    logic [WORD_W-1:0] faddr_q;

    logic [1:0]        size;
    logic [OFF_W-1:0]  offset;
    logic              in_ram, in_mmio, misal, req;
    logic [CODE_W-1:0] fcode;
    logic              ok, ram_rd, ram_wr, mmio_rd, mmio_wr, fstat_clr;
    logic [LANES-1:0]  st_mask;
    logic [WORD_W-1:0] st_lanes, ld_data, ram_rword, merged, mmio_rdata;
    logic              unused_type;

    assign unused_type = MEM_type[2];
    assign size        = MEM_type[1:0];
    assign offset      = MEM_addr[OFF_W-1:0];
    assign req         = MEM_rd_en | MEM_wr_en;
    assign in_ram      = {1'b0, MEM_addr} < RAM_BYTES;
    assign in_mmio     = MEM_addr[31:OFF_W] == MMIO_BASE[31:OFF_W];
    assign misal       = (size == 2'b11)
                       | ((size == SZ_HALF) & MEM_addr[0])
                       | ((size == SZ_WORD) & (MEM_addr[1:0] != 2'b00));

    // Legality check in priority order
    always_comb begin
        fcode = F_NONE;
        if (MEM_rd_en && MEM_wr_en) begin
            fcode = F_CONFLICT;
        end else if (req && (misal || (in_mmio && size != SZ_WORD))) begin
            fcode = F_MISALIGN;
        end else if (req && !in_ram && !in_mmio) begin
            fcode = F_RANGE;
        end
    end

    assign ok        = (fcode == F_NONE);
    assign ram_rd    = MEM_rd_en & ok & in_ram;
    assign ram_wr    = MEM_wr_en & ok & in_ram;
    assign mmio_rd   = MEM_rd_en & ok & in_mmio;
    assign mmio_wr   = MEM_wr_en & ok & in_mmio;
    assign fstat_clr = mmio_rd & (offset == OFF_FSTAT);

    mem_lane_align u_align (
        .size     (size),
        .addr_lo  (MEM_addr[1:0]),
        .st_data  (MEM_WR_out),
        .ld_word  (merged),
        .mask     (st_mask),
        .st_lanes (st_lanes),
        .ld_data  (ld_data)
    );

    // Load path: RAM word overlaid with any matching pending bytes
    assign ram_rword = ram[MEM_addr[AW+1:2]];

    always_comb begin
        merged = ram_rword;
        for (int i = 0; i < int'(LANES); i++) begin
            if (pend.valid && pend.word_idx == MEM_addr[31:2] && pend.mask[i]) begin
                merged[8*i +: 8] = pend.data[8*i +: 8];
            end
        end
    end

    always_comb begin
        mmio_rdata = '0;
        case (offset)
            OFF_CYCLE:  mmio_rdata = cycle_q;
            OFF_TOHOST: mmio_rdata = tohost_q;
            OFF_FSTAT:  mmio_rdata = {30'h0, fstat_q};
            OFF_FADDR:  mmio_rdata = faddr_q;
            default:    mmio_rdata = '0;
        endcase
    end

    always_comb begin
        MEM_data = '0;
        if (!rst) begin
            if (ram_rd) begin
                MEM_data = ld_data;
            end else if (mmio_rd) begin
                MEM_data = mmio_rdata;
            end
        end
    end

    // Store buffer capture; a new store replaces the entry being committed
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend.valid <= ram_wr;
            if (ram_wr) begin
                pend.word_idx <= MEM_addr[31:2];
                pend.mask     <= st_mask;
                pend.data     <= st_lanes;
            end
        end
    end

    // RAM commit of the pending entry (RAM itself is not reset)
    always_ff @(posedge CLK) begin
        if (pend.valid) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (pend.mask[i]) begin
                    ram[pend.word_idx[AW-1:0]][8*i +: 8] <= pend.data[8*i +: 8];
                end
            end
        end
    end

    // MMIO registers
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            cycle_q  <= '0;
            tohost_q <= '0;
            halt     <= 1'b0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (mmio_wr && offset == OFF_TOHOST) begin
                tohost_q <= MEM_WR_out;
                halt     <= 1'b1;
            end
        end
    end

    // Fault capture: first fault wins until FSTAT is read; a new fault beats the clear
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            fault   <= 1'b0;
            fstat_q <= F_NONE;
            faddr_q <= '0;
        end else begin
            if (!ok && (!fault || fstat_clr)) begin
                fault   <= 1'b1;
                fstat_q <= fcode;
                faddr_q <= MEM_addr;
            end else if (fstat_clr) begin
                fault   <= 1'b0;
                fstat_q <= F_NONE;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: the driver pushes hand-computed
// expectations per cycle; a monitor pops and compares whenever a load is
// presented or a probe cycle is marked.
module tb_data_mem_responder;

    localparam logic [31:0] MB = 32'hFFFF_0000;

    logic        CLK = 1'b0;
    logic        rst;
    logic [31:0] MEM_addr;
    logic [31:0] MEM_WR_out;
    logic [2:0]  MEM_type;
    logic        MEM_rd_en;
    logic        MEM_wr_en;
    logic [31:0] MEM_data;
    logic        fault;
    logic        halt;
    logic        probe;

    int checks = 0;
    int errors = 0;

    string       name_q[$];
    logic [31:0] data_q[$];
    logic        fault_q[$];
    logic        halt_q[$];

    data_mem_responder #(.DEPTH_WORDS(1024), .MMIO_BASE(MB)) dut (
        .CLK        (CLK),
        .rst        (rst),
        .MEM_addr   (MEM_addr),
        .MEM_WR_out (MEM_WR_out),
        .MEM_type   (MEM_type),
        .MEM_rd_en  (MEM_rd_en),
        .MEM_wr_en  (MEM_wr_en),
        .MEM_data   (MEM_data),
        .fault      (fault),
        .halt       (halt)
    );

    always #5 CLK = ~CLK;

    // Drive one request cycle at the falling edge; queue its expectation
    task automatic cyc(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [2:0] t, input logic [31:0] wd, input logic chk,
                       input logic [31:0] ed, input logic ef, input logic eh,
                       input string nm);
        @(negedge CLK);
        MEM_rd_en  = rd;
        MEM_wr_en  = wr;
        MEM_addr   = a;
        MEM_type   = t;
        MEM_WR_out = wd;
        probe      = chk;
        if (rd || chk) begin
            name_q.push_back(nm);
            data_q.push_back(ed);
            fault_q.push_back(ef);
            halt_q.push_back(eh);
        end
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, "idle");
    endtask

    task automatic ld(input logic [31:0] a, input logic [2:0] t,
                      input logic [31:0] ed, input logic ef, input logic eh, input string nm);
        cyc(1'b1, 1'b0, a, t, 32'h0, 1'b0, ed, ef, eh, nm);
    endtask

    task automatic st(input logic [31:0] a, input logic [2:0] t, input logic [31:0] wd);
        cyc(1'b0, 1'b1, a, t, wd, 1'b0, 32'h0, 1'b0, 1'b0, "store");
    endtask

    // Monitor: sample mid-low-phase, well away from the rising edge
    initial begin
        string       nm;
        logic [31:0] ed;
        logic        ef, eh;
        forever begin
            @(negedge CLK);
            #2;
            if (MEM_rd_en || probe) begin
                if (name_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output data got %h with empty scoreboard", MEM_data);
                end else begin
                    nm = name_q.pop_front();
                    ed = data_q.pop_front();
                    ef = fault_q.pop_front();
                    eh = halt_q.pop_front();
                    checks++;
                    if (MEM_data !== ed) begin
                        errors++;
                        $display("FAIL %s data got %h exp %h", nm, MEM_data, ed);
                    end
                    checks++;
                    if (fault !== ef) begin
                        errors++;
                        $display("FAIL %s fault got %b exp %b", nm, fault, ef);
                    end
                    checks++;
                    if (halt !== eh) begin
                        errors++;
                        $display("FAIL %s halt got %b exp %b", nm, halt, eh);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        MEM_addr   = '0;
        MEM_WR_out = '0;
        MEM_type   = '0;
        MEM_rd_en  = 1'b0;
        MEM_wr_en  = 1'b0;
        probe      = 1'b0;

        cyc(1'b0, 1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, "reset_state");
        idle();
        rst = 1'b0;                                 // counter is 0 in this cycle
        repeat (4) idle();
        ld(MB + 32'h0, 3'd2, 32'd5, 1'b0, 1'b0, "cycle_at_5");
        st(MB + 32'h0, 3'd2, 32'h0);                // CYCLE write ignored, no fault
        idle();
        ld(MB + 32'h0, 3'd2, 32'd8, 1'b0, 1'b0, "cycle_at_8");

        // Forward path then RAM path
        st(32'h10, 3'd2, 32'hDEAD_BEEF);
        ld(32'h10, 3'd2, 32'hDEAD_BEEF, 1'b0, 1'b0, "fwd_word");
        ld(32'h10, 3'd2, 32'hDEAD_BEEF, 1'b0, 1'b0, "ram_word");

        // Partial forward merge and sub-word loads
        st(32'h20, 3'd2, 32'h1122_3344);
        st(32'h21, 3'd0, 32'h0000_00AA);
        ld(32'h20, 3'd2, 32'h1122_AA44, 1'b0, 1'b0, "fwd_merge");
        ld(32'h22, 3'd1, 32'h0000_1122, 1'b0, 1'b0, "load_half_hi");
        ld(32'h21, 3'd4, 32'h0000_00AA, 1'b0, 1'b0, "load_byte_zext");

        // Last RAM word
        st(32'hFFE, 3'd1, 32'h1234_BEEF);
        idle();
        ld(32'hFFE, 3'd1, 32'h0000_BEEF, 1'b0, 1'b0, "top_half");
        ld(32'hFFF, 3'd0, 32'h0000_00BE, 1'b0, 1'b0, "top_byte");

        // Misaligned load, status readback and clear
        ld(32'h06, 3'd2, 32'h0, 1'b0, 1'b0, "misalign_load");
        ld(MB + 32'h8, 3'd2, 32'd1, 1'b1, 1'b0, "fstat_misalign");
        ld(MB + 32'hC, 3'd2, 32'h6, 1'b0, 1'b0, "faddr_6");
        ld(MB + 32'h8, 3'd2, 32'd0, 1'b0, 1'b0, "fstat_cleared");

        // Read/write conflict leaves RAM untouched
        st(32'h0, 3'd2, 32'h0BAD_F00D);
        idle();
        cyc(1'b1, 1'b1, 32'h0, 3'd2, 32'h5555_5555, 1'b0, 32'h0, 1'b0, 1'b0, "conflict");
        ld(MB + 32'h8, 3'd2, 32'd3, 1'b1, 1'b0, "fstat_conflict");
        ld(32'h0, 3'd2, 32'h0BAD_F00D, 1'b0, 1'b0, "ram_unchanged");

        // Out of range just past the RAM
        ld(32'h1000, 3'd2, 32'h0, 1'b0, 1'b0, "range_load");
        ld(MB + 32'h8, 3'd2, 32'd2, 1'b1, 1'b0, "fstat_range");

        // First fault wins
        ld(32'h3, 3'd1, 32'h0, 1'b0, 1'b0, "misalign_half");
        ld(32'h2000, 3'd2, 32'h0, 1'b1, 1'b0, "second_fault");
        ld(MB + 32'h8, 3'd2, 32'd1, 1'b1, 1'b0, "fstat_first_wins");
        ld(MB + 32'hC, 3'd2, 32'h3, 1'b0, 1'b0, "faddr_first_wins");

        // Sub-word MMIO access
        ld(MB + 32'h4, 3'd0, 32'h0, 1'b0, 1'b0, "mmio_byte");
        ld(MB + 32'h8, 3'd2, 32'd1, 1'b1, 1'b0, "fstat_mmio_byte");

        // TOHOST and halt
        cyc(1'b0, 1'b1, MB + 32'h4, 3'd2, 32'h1, 1'b1, 32'h0, 1'b0, 1'b0, "tohost_wr");
        ld(MB + 32'h4, 3'd2, 32'h1, 1'b0, 1'b1, "tohost_rd");
        cyc(1'b0, 1'b1, MB + 32'h4, 3'd2, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, "tohost_wr0");
        ld(MB + 32'h4, 3'd2, 32'h0, 1'b0, 1'b1, "halt_sticky");

        // Reset before commit discards the pending store
        st(32'h40, 3'd2, 32'h1234_5678);
        idle();
        st(32'h40, 3'd2, 32'hCAFE_F00D);
        ld(32'h40, 3'd2, 32'h0, 1'b0, 1'b0, "in_reset");
        rst = 1'b1;
        idle();
        rst = 1'b0;
        ld(32'h40, 3'd2, 32'h1234_5678, 1'b0, 1'b0, "store_discarded");
        ld(MB + 32'h4, 3'd2, 32'h0, 1'b0, 1'b0, "tohost_after_reset");

        idle();
        idle();
        checks++;
        if (name_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d exp 0", name_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
